key_cmd_debouncer: RTL and testbench

Upstream front-end for the audio recorder/player control FSM. Takes the three raw, active-low board push-buttons (record, play, stop) and produces clean, synchronized, single-cycle command pulses in the control FSM's clock domain. Each key gets its own debounce state machine. A fixed priority resolver guarantees that at most one command pulse is issued per cycle.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 117 +++++++++++
 rtl/key_cmd_debouncer.sv | 50 +++++
 tb/tb_key_cmd_debouncer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the push-button command front-end.
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
package key_pkg;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    PRS       = 2'd2,
    REL_CHK   = 2'd3
  } key_state_e;

  localparam int KEY_REC  = 0;
  localparam int KEY_PLAY = 1;
  localparam int KEY_STOP = 2;
  localparam int NUM_KEYS = 3;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, debounce counter and,
// with KEY_LONG_PRESS_EN defined, a saturating long-press counter.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 24000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       level,
  output logic       press,
  output logic       long_pulse,
  output key_state_e state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Reset parks the synchronizer at "released" so no spurious press follows reset.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n};
  end

  assign s = ~sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REL;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      REL: begin
        cnt_d = '0;
        if (s) state_d = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRS;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRS: begin
        cnt_d = '0;
        if (!s) state_d = REL_CHK;
      end
      REL_CHK: begin
        if (s) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = (state_q == PRS) || (state_q == REL_CHK);
  assign press = press_q;
  assign state = state_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt_q;
  logic              long_q;

  // Counts while the key is accepted as held; saturation keeps the pulse to one per press.
  always_ff @(posedge clk) begin
    if (rst || !level) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= (long_cnt_q == LONG_MAX - 1'b1);
      if (long_cnt_q != LONG_MAX) long_cnt_q <= long_cnt_q + 1'b1;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_cmd_debouncer.sv
// Three debounced push-buttons to single-cycle, priority-resolved command pulses
// (stop > play > record). Long-press pulses require KEY_LONG_PRESS_EN.
module key_cmd_debouncer
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 24000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_level,
  output logic                o_key_0,
  output logic                o_key_1,
  output logic                o_key_2,
  output logic [NUM_KEYS-1:0] o_long
);

  logic [NUM_KEYS-1:0] press;
  key_state_e          ch_state [NUM_KEYS];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk        (i_clk),
      .rst        (i_rst),
      .key_n      (i_key_n[k]),
      .level      (o_level[k]),
      .press      (press[k]),
      .long_pulse (o_long[k]),
      .state      (ch_state[k])
    );
  end

  // Losing simultaneous events are dropped rather than queued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_key_0 <= 1'b0;
      o_key_1 <= 1'b0;
      o_key_2 <= 1'b0;
    end else begin
      o_key_2 <= press[KEY_STOP];
      o_key_1 <= press[KEY_PLAY] & ~press[KEY_STOP];
      o_key_0 <= press[KEY_REC] & ~press[KEY_PLAY] & ~press[KEY_STOP];
    end
  end

endmodule

// File: tb/tb_key_cmd_debouncer.sv
// Directed bench for key_cmd_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Long-press expectations follow KEY_LONG_PRESS_EN.
module tb_key_cmd_debouncer;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_n;
  logic [2:0] o_level;
  logic       o_key_0, o_key_1, o_key_2;
  logic [2:0] o_long;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_cmd_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key_n (key_n),
    .o_level (o_level),
    .o_key_0 (o_key_0),
    .o_key_1 (o_key_1),
    .o_key_2 (o_key_2),
    .o_long  (o_long)
  );

  // Cycle c: inputs set before edge c, outputs observed 1 time unit after edge c.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    key_n = 3'b111;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [8:0] obs;
    key_n = 3'b000;
    rst   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      obs = {o_long, o_level, o_key_2, o_key_1, o_key_0};
      checks++;
      if (obs !== 9'd0) begin
        errors++;
        $display("FAIL reset c=%0d got=%b exp=%b", c, obs, 9'd0);
      end
    end
    key_n = 3'b111;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_clean_press;
    logic [5:0] obs, exp;
    do_reset();
    key_n = 3'b110;
    for (int c = 0; c <= 16; c++) begin
      tick();
      obs = {o_level, o_key_2, o_key_1, o_key_0};
      exp = {2'b00, (c >= 6), 2'b00, (c == 7)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clean_press c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_bounce;
    logic [5:0] obs;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      key_n = {1'b1, ((c < 20) ? (((c / 2) % 2) == 1) : 1'b1), 1'b1};
      tick();
      obs = {o_level, o_key_2, o_key_1, o_key_0};
      checks++;
      if (obs !== 6'd0) begin
        errors++;
        $display("FAIL bounce c=%0d got=%b exp=%b", c, obs, 6'd0);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [5:0] obs, exp;
    do_reset();
    key_n = 3'b000;
    for (int c = 0; c <= 14; c++) begin
      tick();
      obs = {o_level, o_key_2, o_key_1, o_key_0};
      exp = {((c >= 6) ? 3'b111 : 3'b000), (c == 7), 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simultaneous c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_release_bounce;
    logic [5:0] obs, exp;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      key_n = {1'b1, !((c <= 11) || (c == 14)), 1'b1};
      tick();
      obs = {o_level, o_key_2, o_key_1, o_key_0};
      exp = {1'b0, ((c >= 6) && (c <= 20)), 1'b0, 1'b0, (c == 7), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL release_bounce c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] obs, exp;
    do_reset();
    key_n = 3'b110;
    for (int c = 0; c <= 16; c++) begin
      rst = (c == 4);
      tick();
      obs = {o_long, o_level, o_key_2, o_key_1, o_key_0};
      exp = {3'b000, 2'b00, (c >= 11), 2'b00, (c == 12)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_long_press;
    logic [8:0] obs, exp;
    logic       long_exp;
    do_reset();
    key_n = 3'b011;
    for (int c = 0; c <= 40; c++) begin
      tick();
`ifdef KEY_LONG_PRESS_EN
      long_exp = (c == 26);
`else
      long_exp = 1'b0;
`endif
      obs = {o_long, o_level, o_key_2, o_key_1, o_key_0};
      exp = {long_exp, 2'b00, (c >= 6), 2'b00, (c == 7), 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_press c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] obs, exp;
    do_reset();
    // Press at 0, release sampled from 10, re-press sampled from 20.
    for (int c = 0; c <= 32; c++) begin
      key_n = {2'b11, ((c >= 10) && (c < 20))};
      tick();
      obs = {o_level, o_key_2, o_key_1, o_key_0};
      exp = {2'b00, (((c >= 6) && (c < 16)) || (c >= 26)), 2'b00, ((c == 7) || (c == 27))};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    key_n = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release_bounce();
    test_reset_mid();
    test_long_press();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
